imc_scheduler: RTL and testbench

- Shares one IMC core between N_REQ input wrappers.
- Arbitrates requests round-robin, latches the winner's four operands and pulses the IMC start.
- Waits for the IMC result, then routes it back to the winning requester with a one-hot response pulse.
- A watchdog aborts hung IMC operations.
- Sits between the in_wrapper instances and the IMC core.

---
 rtl/imc_scheduler_pkg.sv | 19 +
 rtl/imc_rr_pick.sv | 33 +++
 rtl/imc_scheduler.sv | 133 +++++++++++++
 tb/tb_imc_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/imc_scheduler_pkg.sv
// Shared types and helpers for the IMC scheduler: FSM state encoding,
// error-counter width and the packed-operand slice index.
package imc_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 8;

  // LSB of operand 'op' (0=a .. 3=d) of requester k in the packed request bus.
  function automatic int op_lsb(input int k, input int op, input int data_w);
    return (k * 4 + op) * data_w;
  endfunction

endpackage

// File: rtl/imc_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_REQ. Returns one-hot grant, binary index and a hit flag.
module imc_rr_pick
  import imc_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = (int'(ptr) + i) % N_REQ;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/imc_scheduler.sv
// Shares one IMC core between N_REQ requesters: round-robin grant, operand
// latch, start pulse, result routing back to the winner, and a BUSY watchdog.
//
// Handshake: a requester holds req_i high until it sees its gnt_o bit (one
// cycle, operands sampled at that edge); its answer arrives later as a
// one-cycle rsp_valid_o bit with rsp_data_o/rsp_err_o qualified by it. The
// IMC side takes imc_start_o only when imc_ready_i was high, and returns
// exactly one imc_valid_i pulse, honoured only in BUSY.
module imc_scheduler
  import imc_scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*4*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]            gnt_o,
  output logic [N_REQ-1:0]            rsp_valid_o,
  output logic [RES_W-1:0]            rsp_data_o,
  output logic                        rsp_err_o,
  input  logic                        imc_ready_i,
  output logic                        imc_start_o,
  output logic [DATA_W-1:0]           imc_a_o,
  output logic [DATA_W-1:0]           imc_b_o,
  output logic [DATA_W-1:0]           imc_c_o,
  output logic [DATA_W-1:0]           imc_d_o,
  input  logic                        imc_valid_i,
  input  logic [RES_W-1:0]            imc_result_i,
  output logic [ERR_CNT_W-1:0]        err_cnt_o,
  output logic [1:0]                  dbg_state_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);

  state_t           state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n, win_idx, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic [WD_W-1:0]  wd_cnt;
  logic             do_grant, rsp_ok, rsp_to;

  imc_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign ptr_n       = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign dbg_state_o = state;

  always_comb begin
    state_n  = state;
    do_grant = 1'b0;
    rsp_ok   = 1'b0;
    rsp_to   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any && imc_ready_i) begin
          do_grant = 1'b1;
          state_n  = START;
        end
      end
      START: state_n = BUSY;
      BUSY: begin
        // A result in the last watchdog cycle still counts as success.
        if (imc_valid_i) begin
          rsp_ok  = 1'b1;
          state_n = RESP;
        end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          rsp_to  = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      win_idx     <= '0;
      wd_cnt      <= '0;
      gnt_o       <= '0;
      imc_start_o <= 1'b0;
      imc_a_o     <= '0;
      imc_b_o     <= '0;
      imc_c_o     <= '0;
      imc_d_o     <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      state       <= state_n;
      gnt_o       <= do_grant ? pick_gnt : '0;
      imc_start_o <= do_grant;
      if (do_grant) begin
        imc_a_o <= req_data_i[op_lsb(int'(pick_idx), 0, DATA_W) +: DATA_W];
        imc_b_o <= req_data_i[op_lsb(int'(pick_idx), 1, DATA_W) +: DATA_W];
        imc_c_o <= req_data_i[op_lsb(int'(pick_idx), 2, DATA_W) +: DATA_W];
        imc_d_o <= req_data_i[op_lsb(int'(pick_idx), 3, DATA_W) +: DATA_W];
        win_idx <= pick_idx;
        ptr     <= ptr_n;
      end

      if (state == START) begin
        wd_cnt <= '0;
      end else if (state == BUSY && !rsp_ok && !rsp_to) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      rsp_valid_o <= (rsp_ok || rsp_to) ? (N_REQ'(1) << win_idx) : '0;
      rsp_data_o  <= rsp_ok ? imc_result_i : '0;
      rsp_err_o   <= rsp_to;
      if (rsp_to && (err_cnt_o != '1)) begin
        err_cnt_o <= err_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imc_scheduler.sv
// Directed bench for imc_scheduler: grants, operand latch, result routing,
// ready gating, watchdog abort, timeout boundary and mid-operation reset.
module tb_imc_scheduler;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int RW   = 32;
  localparam int TO   = 8;
  localparam int SB_W = 1 + N + RW;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*4*DW-1:0] req_data;
  logic [N-1:0]      gnt_o, rsp_valid_o;
  logic [RW-1:0]     rsp_data_o;
  logic              rsp_err_o;
  logic              imc_ready, imc_start_o, imc_valid;
  logic [DW-1:0]     imc_a_o, imc_b_o, imc_c_o, imc_d_o;
  logic [RW-1:0]     imc_result;
  logic [7:0]        err_cnt_o;
  logic [1:0]        dbg_state_o;

  int total = 0;
  int bad   = 0;
  int n;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] exp_v;

  always #5 clk = ~clk;

  imc_scheduler #(
    .N_REQ (N), .DATA_W (DW), .RES_W (RW), .TIMEOUT (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .req_data_i   (req_data),
    .gnt_o        (gnt_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_err_o    (rsp_err_o),
    .imc_ready_i  (imc_ready),
    .imc_start_o  (imc_start_o),
    .imc_a_o      (imc_a_o),
    .imc_b_o      (imc_b_o),
    .imc_c_o      (imc_c_o),
    .imc_d_o      (imc_d_o),
    .imc_valid_i  (imc_valid),
    .imc_result_i (imc_result),
    .err_cnt_o    (err_cnt_o),
    .dbg_state_o  (dbg_state_o)
  );

  function automatic logic [DW-1:0] op_val(input int k, input int j);
    return DW'(k * 16 + j + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits up to max_t cycles for a response, then pops and compares it.
  task automatic wait_rsp(input int max_t, output int waited);
    waited = 0;
    while (rsp_valid_o == '0 && waited < max_t) begin
      tick();
      waited++;
    end
    chk("rsp_arrive", 64'(|rsp_valid_o), 64'(1));
    if (rsp_valid_o != '0) begin
      chk("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        chk("rsp_word", 64'({rsp_err_o, rsp_valid_o, rsp_data_o}), 64'(exp_v));
      end
    end
  endtask

  // Called with the DUT in IDLE and requester k's request already visible.
  task automatic run_op(input int k, input logic [RW-1:0] res, input int lat, input bit keep_req);
    int w;
    tick();
    chk("gnt", 64'(gnt_o), 64'(1 << k));
    chk("start", 64'(imc_start_o), 64'(1));
    chk("op_a", 64'(imc_a_o), 64'(op_val(k, 0)));
    chk("op_b", 64'(imc_b_o), 64'(op_val(k, 1)));
    chk("op_c", 64'(imc_c_o), 64'(op_val(k, 2)));
    chk("op_d", 64'(imc_d_o), 64'(op_val(k, 3)));
    if (!keep_req) req[k] = 1'b0;
    exp_q.push_back({1'b0, N'(1 << k), res});
    tick();
    chk("gnt_clear", 64'(gnt_o), 64'(0));
    chk("start_clear", 64'(imc_start_o), 64'(0));
    repeat (lat - 2) tick();
    imc_valid  = 1'b1;
    imc_result = res;
    tick();
    imc_valid  = 1'b0;
    imc_result = '0;
    wait_rsp(2, w);
    chk("rsp_lat", 64'(w), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst        = 1'b1;
    req        = '0;
    imc_ready  = 1'b1;
    imc_valid  = 1'b0;
    imc_result = '0;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 4; j++)
        req_data[(k * 4 + j) * DW +: DW] = op_val(k, j);

    // Reset state
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst_state", 64'(dbg_state_o), 64'(0));
    chk("rst_gnt", 64'(gnt_o), 64'(0));
    chk("rst_start", 64'(imc_start_o), 64'(0));
    chk("rst_rsp", 64'({rsp_err_o, rsp_valid_o, rsp_data_o}), 64'(0));
    chk("rst_ops", 64'({imc_a_o, imc_b_o, imc_c_o, imc_d_o}), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt_o), 64'(0));

    // Single request, IMC answers 3 cycles after start
    req = 4'b0001;
    run_op(0, 32'h0000_0032, 3, 1'b0);
    tick();

    // Ready low holds off the grant
    req       = 4'b0100;
    imc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ready_low_gnt", 64'(gnt_o), 64'(0));
      chk("ready_low_start", 64'(imc_start_o), 64'(0));
    end
    imc_ready = 1'b1;
    run_op(2, 32'h0bad_f00d, 2, 1'b0);
    tick();

    // Watchdog abort: no IMC valid at all
    req = 4'b0010;
    tick();
    chk("to_gnt", 64'(gnt_o), 64'(4'b0010));
    req = '0;
    exp_q.push_back({1'b1, N'(4'b0010), 32'h0});
    repeat (TO) tick();
    chk("to_early", 64'(rsp_valid_o), 64'(0));
    tick();
    wait_rsp(0, n);
    chk("to_err_cnt", 64'(err_cnt_o), 64'(1));
    tick();

    // Next request after a timeout is serviced normally
    req = 4'b1000;
    run_op(3, 32'h1234_5678, 4, 1'b0);
    tick();

    // Valid in the last watchdog cycle wins over the timeout
    req = 4'b0001;
    run_op(0, 32'hcafe_0007, TO + 1, 1'b0);
    chk("edge_err_cnt", 64'(err_cnt_o), 64'(1));
    tick();

    // Fairness under full contention, starting from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_err_cnt", 64'(err_cnt_o), 64'(0));
    req = 4'b1111;
    run_op(0, 32'h0000_0100, 2, 1'b1);
    tick();
    run_op(1, 32'h0000_0101, 2, 1'b1);
    tick();
    run_op(2, 32'h0000_0102, 2, 1'b1);
    tick();
    run_op(3, 32'h0000_0103, 2, 1'b1);
    tick();
    run_op(0, 32'h0000_0104, 2, 1'b1);
    req = '0;
    tick();

    // Reset in BUSY: no response, stray valid ignored, pointer back to 0
    req = 4'b0010;
    tick();
    chk("mid_gnt", 64'(gnt_o), 64'(4'b0010));
    req = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_state", 64'(dbg_state_o), 64'(0));
    chk("mid_outs", 64'({gnt_o, imc_start_o, rsp_valid_o, rsp_err_o}), 64'(0));
    chk("mid_data", 64'(rsp_data_o), 64'(0));
    chk("mid_ops", 64'({imc_a_o, imc_b_o, imc_c_o, imc_d_o}), 64'(0));
    tick();
    imc_valid  = 1'b1;
    imc_result = 32'hdead_beef;
    tick();
    imc_valid  = 1'b0;
    imc_result = '0;
    chk("stray_rsp0", 64'({rsp_valid_o, rsp_data_o}), 64'(0));
    tick();
    chk("stray_rsp1", 64'({rsp_valid_o, rsp_data_o}), 64'(0));
    req = 4'b1010;
    run_op(1, 32'h0000_0abc, 2, 1'b0);
    req = '0;
    tick();

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
